// File: rtl/io_flag_ctrl_if.sv
// Peripheral-side handshake bundle for the two I/O channels (ch0 = GPIO, ch1 = UART).
// Latency: wires only, no storage.
// Backpressure: valid/ready per channel and per direction. Channel 1 occupies the upper DW bits.
interface io_flag_ctrl_if #(
   parameter int DW = 8
);
   logic [1:0]      in_valid;
   logic [2*DW-1:0] in_data;
   logic [1:0]      in_ready;
   logic [1:0]      out_valid;
   logic [2*DW-1:0] out_data;
   logic [1:0]      out_ready;

   // Controller side: accepts input bytes and offers output bytes.
   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   // Peripheral side: offers input bytes and accepts output bytes.
   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/io_flag_ctrl.sv
// I/O flag controller: INPR/OUTR, FGI/FGO, IEN, IMSK and a round-robin interrupt source picker.
// Latency: an input byte raises fgi 1 clk after the handshake; a CPU write raises out_valid 1 clk later.
// Backpressure: in_ready = ~fgi (one byte per channel); out_data is held until out_ready.
module io_flag_ctrl #(
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_sel,
   input  logic                cpu_inp,
   input  logic                cpu_out,
   input  logic [DW-1:0]       cpu_outd,
   input  logic                cpu_ion,
   input  logic                cpu_iof,
   input  logic                imsk_we,
   input  logic [3:0]          imsk_d,
   input  logic                irq_ack,
   io_flag_ctrl_if.master      pif,
   output logic [DW-1:0]       inpr,
   output logic [1:0]          fgi,
   output logic [1:0]          fgo,
   output logic                ien,
   output logic [3:0]          imsk,
   output logic                irq,
   output logic [1:0]          irq_src,
   output logic [1:0]          err
);

   logic [1:0][DW-1:0] inpr_q, inpr_d;
   logic [1:0][DW-1:0] outr_q, outr_d;
   logic [1:0]         fgi_q, fgi_d;
   logic [1:0]         fgo_q, fgo_d;
   logic [1:0]         ov_q, ov_d;
   logic [1:0]         err_q, err_d;
   logic               ien_q, ien_d;
   logic [3:0]         msk_q, msk_d;
   logic [1:0]         irq_src_q, irq_src_d;
   logic [1:0]         rr_ptr_q, rr_ptr_d;

   logic [3:0]         pend;
   logic               irq_w;
   logic [1:0]         rr_sel;
   logic               rr_found;
   logic [1:0]         rr_idx;

   // Pending sources, interrupt request and round-robin pick starting at rr_ptr.
   always_comb begin
      pend     = {fgo_q[1], fgi_q[1], fgo_q[0], fgi_q[0]} & msk_q;
      irq_w    = ien_q & (|pend);
      rr_sel   = 2'd0;
      rr_found = 1'b0;
      rr_idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         rr_idx = rr_ptr_q + 2'(i);
         if (!rr_found && pend[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   // Next state for the per-channel input/output flag machines and the control registers.
   always_comb begin
      inpr_d    = inpr_q;
      outr_d    = outr_q;
      fgi_d     = fgi_q;
      fgo_d     = fgo_q;
      ov_d      = ov_q;
      err_d     = err_q;
      ien_d     = ien_q;
      msk_d     = msk_q;
      irq_src_d = irq_src_q;
      rr_ptr_d  = rr_ptr_q;

      for (int ch = 0; ch < 2; ch++) begin
         // Input side: FULL only drains on a CPU read; EMPTY takes a byte when offered.
         if (fgi_q[ch]) begin
            if (cpu_inp && (cpu_sel == 1'(ch)))
               fgi_d[ch] = 1'b0;
         end else begin
            if (cpu_inp && (cpu_sel == 1'(ch)))
               err_d[ch] = 1'b1;
            if (pif.in_valid[ch]) begin
               fgi_d[ch]  = 1'b1;
               inpr_d[ch] = pif.in_data[ch*DW +: DW];
            end
         end
         // Output side: IDLE loads OUTR on a CPU write; SEND waits for the peripheral.
         if (fgo_q[ch]) begin
            if (cpu_out && (cpu_sel == 1'(ch))) begin
               outr_d[ch] = cpu_outd;
               fgo_d[ch]  = 1'b0;
               ov_d[ch]   = 1'b1;
            end
         end else begin
            if (cpu_out && (cpu_sel == 1'(ch)))
               err_d[ch] = 1'b1;
            if (ov_q[ch] && pif.out_ready[ch]) begin
               fgo_d[ch] = 1'b1;
               ov_d[ch]  = 1'b0;
            end
         end
      end

      // Acknowledge latches the source and advances the pointer past it.
      if (irq_ack && irq_w) begin
         irq_src_d = rr_sel;
         rr_ptr_d  = rr_sel + 2'd1;
      end

      // IEN priority: IOF beats an accepted acknowledge, which beats ION.
      if (cpu_iof)
         ien_d = 1'b0;
      else if (irq_ack && irq_w)
         ien_d = 1'b0;
      else if (cpu_ion)
         ien_d = 1'b1;

      if (imsk_we)
         msk_d = imsk_d;
   end

   // State registers with synchronous reset; reset drops any byte in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inpr_q    <= '0;
         outr_q    <= '0;
         fgi_q     <= 2'b00;
         fgo_q     <= 2'b11;
         ov_q      <= 2'b00;
         err_q     <= 2'b00;
         ien_q     <= 1'b0;
         msk_q     <= 4'h0;
         irq_src_q <= 2'd0;
         rr_ptr_q  <= 2'd0;
      end else begin
         inpr_q    <= inpr_d;
         outr_q    <= outr_d;
         fgi_q     <= fgi_d;
         fgo_q     <= fgo_d;
         ov_q      <= ov_d;
         err_q     <= err_d;
         ien_q     <= ien_d;
         msk_q     <= msk_d;
         irq_src_q <= irq_src_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign pif.in_ready  = ~fgi_q;
   assign pif.out_valid = ov_q;
   assign pif.out_data  = outr_q;
   assign inpr          = inpr_q[cpu_sel];
   assign fgi           = fgi_q;
   assign fgo           = fgo_q;
   assign ien           = ien_q;
   assign imsk          = msk_q;
   assign irq           = irq_w;
   assign irq_src       = irq_src_q;
   assign err           = err_q;

endmodule
